// File: rtl/lottery_pkg.sv
// Shared types and constants for the lottery round controller.
// Optional feature macro: LOTTERY_ACK_TIMEOUT_EN (coin acknowledge watchdog).
package lottery_pkg;

   localparam int SUM_W       = 10;   // accumulated sum width
   localparam int H_W         = 3;    // hundreds payout digit width
   localparam int D_W         = 4;    // tens / ones payout digit width
   localparam int CNT_W       = 4;    // draw counter width (up to 15 draws)
   localparam int SUM_MAX_DEF = 999;  // default saturation ceiling

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DRAW,
      ST_FIN,
      ST_EVAL,
      ST_PAY,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      COIN_1   = 2'b00,
      COIN_10  = 2'b01,
      COIN_100 = 2'b10
   } coin_t;

   // Saturating add of a 7-bit draw onto the running sum; one extra bit catches the carry.
   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [6:0]       b,
                                                input logic [SUM_W-1:0] ceil);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W-6){1'b0}}, b};
      if (s > {1'b0, ceil}) return ceil;
      return s[SUM_W-1:0];
   endfunction

endpackage

// File: rtl/lottery_ctrl_if.sv
// Bus between the lottery controller and its environment (draw source, cash
// datapath, coin dispenser).
// Handshake: a coin is transferred on every rising edge where coin_req and
// coin_ack are both high; coin_req/coin_type stay stable until then, and
// coin_ack without coin_req has no effect. V qualifies draw_val each cycle.
interface lottery_ctrl_if;
   import lottery_pkg::*;

   logic             start;
   logic             V;
   logic [6:0]       draw_val;
   logic [SUM_W-1:0] sum;
   logic             finish;
   logic             winner;
   logic             not_a_win;
   logic [H_W-1:0]   Eur100;
   logic [D_W-1:0]   Eur010;
   logic [D_W-1:0]   Eur001;
   logic             coin_req;
   logic [1:0]       coin_type;
   logic             coin_ack;
   logic             busy;
   logic             done;
   logic             err;
   state_t           dbg_state;

   // Controller side.
   modport slave (
      input  start, V, draw_val, winner, not_a_win, Eur100, Eur010, Eur001, coin_ack,
      output sum, finish, coin_req, coin_type, busy, done, err, dbg_state
   );

   // Environment side.
   modport master (
      output start, V, draw_val, winner, not_a_win, Eur100, Eur010, Eur001, coin_ack,
      input  sum, finish, coin_req, coin_type, busy, done, err, dbg_state
   );

endinterface

// File: rtl/lottery_ctrl_payout_seq.sv
// Payout sequencer: BCD down-counters for 100/10/1 coins, dispensed in that
// order over the req/ack handshake. Empty denominations are skipped without a
// request cycle. With LOTTERY_ACK_TIMEOUT_EN an 8-bit watchdog aborts a coin
// that waits 255 cycles for its acknowledge.
module payout_seq
   import lottery_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           active,
   input  logic [H_W-1:0] eur100,
   input  logic [D_W-1:0] eur010,
   input  logic [D_W-1:0] eur001,
   input  logic           coin_ack,
   output logic           coin_req,
   output logic [1:0]     coin_type,
   output logic           pay_empty,
   output logic           timeout
);

   logic [H_W-1:0] cnt100;
   logic [D_W-1:0] cnt010;
   logic [D_W-1:0] cnt001;
   logic           accept;

   assign pay_empty = (cnt100 == '0) && (cnt010 == '0) && (cnt001 == '0);
   assign coin_req  = active && !pay_empty && !timeout;
   assign accept    = coin_req && coin_ack;

   // Denomination of the pending coin: highest non-empty counter wins.
   always_comb begin
      coin_type = COIN_1;
      if (coin_req) begin
         if (cnt100 != '0)      coin_type = COIN_100;
         else if (cnt010 != '0) coin_type = COIN_10;
         else                   coin_type = COIN_1;
      end
   end

   // Load the payout digits, then count down the active denomination per accepted coin.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt100 <= '0;
         cnt010 <= '0;
         cnt001 <= '0;
      end else if (load) begin
         cnt100 <= eur100;
         cnt010 <= eur010;
         cnt001 <= eur001;
      end else if (accept) begin
         if (cnt100 != '0)      cnt100 <= cnt100 - H_W'(1);
         else if (cnt010 != '0) cnt010 <= cnt010 - D_W'(1);
         else                   cnt001 <= cnt001 - D_W'(1);
      end
   end

`ifdef LOTTERY_ACK_TIMEOUT_EN
   logic [7:0] wd;

   // Count unacknowledged request cycles; any accepted coin or leaving PAY restarts it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wd <= '0;
      end else if (load || accept || !active) begin
         wd <= '0;
      end else if (coin_req && !coin_ack && (wd != 8'hFF)) begin
         wd <= wd + 8'd1;
      end
   end

   assign timeout = active && (wd == 8'hFF);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: rtl/lottery_ctrl.sv
// Lottery round controller: accumulates NUM_DRAWS draws into a saturating sum,
// requests a cash evaluation, then hands any win to payout_seq.
// Optional feature macro: LOTTERY_ACK_TIMEOUT_EN (see payout_seq).
module lottery_ctrl
   import lottery_pkg::*;
#(
   parameter int NUM_DRAWS = 5,
   parameter int SUM_MAX   = SUM_MAX_DEF
)
(
   input  logic          clk,
   input  logic          reset,
   lottery_ctrl_if.slave bus
);

   localparam logic [SUM_W-1:0] SUM_CEIL  = SUM_W'(SUM_MAX);
   localparam logic [CNT_W-1:0] LAST_DRAW = CNT_W'(NUM_DRAWS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [SUM_W-1:0] sum_q;
   logic [CNT_W-1:0] count_q;
   logic             err_q;
   logic             load;
   logic             pay_empty;
   logic             timeout;
   logic             verdict_win;
   logic             verdict_bad;

   assign verdict_win = bus.winner && !bus.not_a_win;
   assign verdict_bad = (bus.winner == bus.not_a_win);

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic and payout counter load strobe.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_DRAW;
         ST_DRAW: if (bus.V && (count_q == LAST_DRAW)) state_nxt = ST_FIN;
         ST_FIN:  state_nxt = ST_EVAL;
         ST_EVAL: begin
            if (verdict_win) begin
               load      = 1'b1;
               state_nxt = ST_PAY;
            end else begin
               state_nxt = ST_DONE;
            end
         end
         ST_PAY:  if (timeout || pay_empty) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Accumulator, draw counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sum_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  sum_q   <= '0;
                  count_q <= '0;
                  err_q   <= 1'b0;
               end
            end
            ST_DRAW: begin
               if (bus.V) begin
                  sum_q   <= sat_add(sum_q, bus.draw_val, SUM_CEIL);
                  count_q <= count_q + CNT_W'(1);
               end
            end
            ST_EVAL: if (verdict_bad) err_q <= 1'b1;
            ST_PAY:  if (timeout) err_q <= 1'b1;
            default: ;
         endcase
      end
   end

   payout_seq u_payout (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .active    (state == ST_PAY),
      .eur100    (bus.Eur100),
      .eur010    (bus.Eur010),
      .eur001    (bus.Eur001),
      .coin_ack  (bus.coin_ack),
      .coin_req  (bus.coin_req),
      .coin_type (bus.coin_type),
      .pay_empty (pay_empty),
      .timeout   (timeout)
   );

   assign bus.sum       = sum_q;
   assign bus.finish    = (state == ST_FIN);
   assign bus.busy      = (state != ST_IDLE);
   assign bus.done      = (state == ST_DONE);
   assign bus.err       = err_q;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_lottery_ctrl.sv
// Bench for lottery_ctrl: directed rounds, expected sums/coins/verdicts pushed
// to queues by the driver and popped by a negedge monitor.
module tb_lottery_ctrl;
   import lottery_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lottery_ctrl_if bus ();
   lottery_ctrl_if bus2 ();

   lottery_ctrl #(.NUM_DRAWS(5)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   lottery_ctrl #(.NUM_DRAWS(5), .SUM_MAX(300)) u_dut300 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   int checks = 0;
   int errors = 0;
   int coins_seen = 0;

   logic [9:0]  exp_sum_q[$];
   logic [9:0]  exp_sum2_q[$];
   logic [1:0]  exp_coin_q[$];
   logic [10:0] exp_done_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual event required none", name);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every DUT-presented result against the head of its queue.
   always @(negedge clk) begin
      logic [9:0]  es;
      logic [1:0]  ec;
      logic [10:0] ed;
      if (bus.finish === 1'b1) begin
         if (exp_sum_q.size() == 0) unexpected("finish_extra");
         else begin
            es = exp_sum_q.pop_front();
            check("finish_sum", 32'(bus.sum), 32'(es));
         end
      end
      if ((bus.coin_req === 1'b1) && (bus.coin_ack === 1'b1)) begin
         coins_seen++;
         if (exp_coin_q.size() == 0) unexpected("coin_extra");
         else begin
            ec = exp_coin_q.pop_front();
            check("coin_type", 32'(bus.coin_type), 32'(ec));
         end
      end
      if (bus.done === 1'b1) begin
         if (exp_done_q.size() == 0) unexpected("done_extra");
         else begin
            ed = exp_done_q.pop_front();
            check("done_err_sum", 32'({bus.err, bus.sum}), 32'(ed));
         end
      end
      if (bus2.finish === 1'b1) begin
         if (exp_sum2_q.size() == 0) unexpected("finish2_extra");
         else begin
            es = exp_sum2_q.pop_front();
            check("sat_sum", 32'(bus2.sum), 32'(es));
         end
      end
   end

   // One full round on bus; dly = ack delay per coin (0 = ack held high, <0 = never ack).
   task automatic run_round(input logic [6:0] d[5], input logic w, input logic n,
                            input logic [2:0] e100, input logic [3:0] e10,
                            input logic [3:0] e1, input int dly);
      int         acc;
      int         ncoin;
      int         exp_lat;
      int         lat;
      int         w_cnt;
      int         req_cycles;
      int         exp_req;
      logic       e_err;
      logic       win;
      logic       tout;
      logic       seen_done;
      logic [1:0] held;
      acc = 0;
      for (int i = 0; i < 5; i++) begin
         acc = acc + int'(d[i]);
         if (acc > 999) acc = 999;
      end
      win   = w && !n;
      ncoin = win ? (int'(e100) + int'(e10) + int'(e1)) : 0;
      tout  = win && (ncoin > 0) && (dly < 0);
      e_err = (w == n) || tout;
      if (tout) begin
         exp_lat = 3 + 255;
         exp_req = 255;
         ncoin   = 0;
      end else if (win) begin
         exp_lat = 3 + ncoin * (dly + 1);
         exp_req = ncoin * (dly + 1);
      end else begin
         exp_lat = 2;
         exp_req = 0;
      end
      exp_sum_q.push_back(10'(acc));
      exp_done_q.push_back({e_err, 10'(acc)});
      if (!tout && win) begin
         for (int i = 0; i < int'(e100); i++) exp_coin_q.push_back(2'b10);
         for (int i = 0; i < int'(e10); i++)  exp_coin_q.push_back(2'b01);
         for (int i = 0; i < int'(e1); i++)   exp_coin_q.push_back(2'b00);
      end
      coins_seen    = 0;
      bus.winner    = w;
      bus.not_a_win = n;
      bus.Eur100    = e100;
      bus.Eur010    = e10;
      bus.Eur001    = e1;
      bus.coin_ack  = (dly == 0);
      // A draw offered in IDLE must be ignored.
      bus.V        = 1'b1;
      bus.draw_val = 7'd55;
      cyc();
      bus.V     = 1'b0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      check("busy_in_draw", 32'(bus.busy), 32'd1);
      check("err_cleared_on_start", 32'(bus.err), 32'd0);
      for (int i = 0; i < 5; i++) begin
         bus.V     = 1'b0;
         bus.start = (i == 2);   // start mid-round must be ignored
         cyc();
         bus.start    = 1'b0;
         bus.V        = 1'b1;
         bus.draw_val = d[i];
         cyc();
      end
      // Keep offering a draw during FIN; it must not be accepted.
      bus.draw_val = 7'd77;
      check("finish_after_last_draw", 32'(bus.finish), 32'd1);
      seen_done  = 1'b0;
      lat        = 0;
      w_cnt      = 0;
      req_cycles = 0;
      held       = 2'b00;
      for (int k = 1; k <= 2000 && !seen_done; k++) begin
         cyc();
         bus.V = 1'b0;
         if (bus.done) begin
            seen_done = 1'b1;
            lat       = k;
         end else if (bus.coin_req) begin
            req_cycles++;
            if (dly == 0) bus.coin_ack = 1'b1;
            else if (dly < 0) bus.coin_ack = 1'b0;
            else begin
               if (w_cnt == 0) held = bus.coin_type;
               else check("coin_type_stable", 32'(bus.coin_type), 32'(held));
               if (w_cnt == dly) begin
                  bus.coin_ack = 1'b1;
                  w_cnt        = 0;
               end else begin
                  bus.coin_ack = 1'b0;
                  w_cnt++;
               end
            end
         end else begin
            bus.coin_ack = (dly == 0);
         end
      end
      bus.coin_ack = 1'b0;
      if (!seen_done) unexpected("done_wait_expired");
      check("done_latency", 32'(lat), 32'(exp_lat));
      check("req_cycles", 32'(req_cycles), 32'(exp_req));
      check("coins_counted", 32'(coins_seen), 32'(ncoin));
      cyc();
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_sum_held", 32'(bus.sum), 32'(acc));
      check("idle_err_sticky", 32'(bus.err), 32'(e_err));
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit actual expired required finish");
      $fatal(1);
   end

   initial begin
      bus.start = 0; bus.V = 0; bus.draw_val = 0; bus.winner = 0; bus.not_a_win = 0;
      bus.Eur100 = 0; bus.Eur010 = 0; bus.Eur001 = 0; bus.coin_ack = 0;
      bus2.start = 0; bus2.V = 0; bus2.draw_val = 0; bus2.winner = 0; bus2.not_a_win = 0;
      bus2.Eur100 = 0; bus2.Eur010 = 0; bus2.Eur001 = 0; bus2.coin_ack = 0;
      reset = 1'b0;
      repeat (3) cyc();
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_finish", 32'(bus.finish), 32'd0);
      check("rst_coin_req", 32'(bus.coin_req), 32'd0);
      check("rst_coin_type", 32'(bus.coin_type), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      reset = 1'b1;
      cyc();

      run_round('{7'd20, 7'd30, 7'd40, 7'd50, 7'd60}, 1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 0);
      run_round('{7'd10, 7'd0, 7'd5, 7'd1, 7'd2},     1'b1, 1'b0, 3'd1, 4'd2, 4'd0, 0);
      run_round('{7'd7, 7'd7, 7'd7, 7'd7, 7'd7},      1'b1, 1'b0, 3'd1, 4'd2, 4'd0, 3);
      run_round('{7'd99, 7'd99, 7'd99, 7'd99, 7'd99}, 1'b1, 1'b1, 3'd0, 4'd0, 4'd0, 0);
      run_round('{7'd1, 7'd2, 7'd3, 7'd4, 7'd5},      1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 0);
      run_round('{7'd127, 7'd127, 7'd127, 7'd127, 7'd127}, 1'b1, 1'b0, 3'd0, 4'd0, 4'd0, 0);
      run_round('{7'd0, 7'd0, 7'd0, 7'd0, 7'd0},      1'b1, 1'b0, 3'd2, 4'd0, 4'd3, 0);
`ifdef LOTTERY_ACK_TIMEOUT_EN
      run_round('{7'd3, 7'd3, 7'd3, 7'd3, 7'd3},      1'b1, 1'b0, 3'd1, 4'd0, 4'd0, -1);
`else
      run_round('{7'd3, 7'd3, 7'd3, 7'd3, 7'd3},      1'b1, 1'b0, 3'd0, 4'd0, 4'd1, 300);
`endif

      // Reset in PAY after the first coin: round aborts, no done pulse.
      exp_sum_q.push_back(10'd50);
      exp_coin_q.push_back(2'b10);
      bus.winner = 1; bus.not_a_win = 0;
      bus.Eur100 = 3'd1; bus.Eur010 = 4'd2; bus.Eur001 = 4'd0;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.V        = 1'b1;
         bus.draw_val = 7'd10;
         cyc();
      end
      bus.V = 1'b0;
      for (int k = 0; k < 10 && !bus.coin_req; k++) cyc();
      check("abort_first_req_type", 32'(bus.coin_type), 32'(2'b10));
      bus.coin_ack = 1'b1;
      cyc();
      bus.coin_ack = 1'b0;
      check("abort_second_req", 32'({bus.coin_req, bus.coin_type}), 32'({1'b1, 2'b01}));
      reset = 1'b0;
      cyc();
      check("abort_state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
      check("abort_coin_req", 32'(bus.coin_req), 32'd0);
      check("abort_coin_type", 32'(bus.coin_type), 32'd0);
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_sum", 32'(bus.sum), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      reset = 1'b1;
      repeat (3) cyc();
      check("abort_stays_idle", 32'(bus.busy), 32'd0);

      // Saturation on the SUM_MAX=300 instance.
      exp_sum2_q.push_back(10'd300);
      bus2.not_a_win = 1'b1;
      bus2.start = 1'b1;
      cyc();
      bus2.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus2.V        = 1'b1;
         bus2.draw_val = 7'd99;
         cyc();
      end
      bus2.V = 1'b0;
      begin
         logic seen2;
         seen2 = 1'b0;
         for (int k = 0; k < 20 && !seen2; k++) begin
            if (bus2.done) seen2 = 1'b1;
            else cyc();
         end
         if (!seen2) unexpected("done2_wait_expired");
         check("sat_sum_at_done", 32'(bus2.sum), 32'd300);
         check("sat_err", 32'(bus2.err), 32'd0);
      end
      repeat (2) cyc();

      check("queues_drained",
            32'(exp_sum_q.size() + exp_sum2_q.size() + exp_coin_q.size() + exp_done_q.size()),
            32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lottery_ctrl.md
LOTTERY_CTRL -- requirements
Module: lottery_ctrl

Interface
REQ-001 Parameter NUM_DRAWS, default 5, number of accepted draws per round (1..15).
REQ-002 Parameter SUM_MAX, default 999, saturation ceiling of the accumulated sum.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  starts a round; sampled only in IDLE.
REQ-006 V  input  1  draw valid; sampled only in DRAW.
REQ-007 draw_val  input  7  draw value, 0..99.
REQ-008 sum  output  10  accumulated sum, driven to the cash datapath.
REQ-009 finish  output  1  one-cycle pulse requesting cash evaluation.
REQ-010 winner, not_a_win  input  1 each  verdict from the cash datapath.
REQ-011 Eur100  input  3 / Eur010  input  4 / Eur001  input  4  BCD payout digits from the cash datapath.
REQ-012 coin_req  output  1  coin dispense request.
REQ-013 coin_type  output  2  coin denomination: 2'b10 = 100, 2'b01 = 10, 2'b00 = 1.
REQ-014 coin_ack  input  1  dispenser accepts the current coin.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle end-of-round pulse.
REQ-017 err  output  1  sticky fault flag, cleared on start.

Function
REQ-018 States: IDLE, DRAW, FIN, EVAL, PAY, DONE.
REQ-019 In IDLE, start=1 causes: sum<=0, draw count<=0, err<=0, and a transition to DRAW.
REQ-020 In DRAW, each cycle with V=1: sum<=min(sum+draw_val, SUM_MAX) and count increments.
REQ-021 DRAW exits to FIN in the cycle the count reaches NUM_DRAWS; no further draws are accepted after that.
REQ-022 FIN lasts exactly one cycle; finish=1 and sum is held stable; the next state is EVAL.
REQ-023 EVAL samples the verdict one cycle after finish:
- winner=1, not_a_win=0: load hundreds/tens/ones counters from Eur100/Eur010/Eur001, then go to PAY.
- winner=0, not_a_win=1: go to DONE.
- Any other combination: set err, then go to DONE.
REQ-024 PAY dispenses all hundreds, then all tens, then all ones.
- coin_req and coin_type are held stable until coin_ack.
- Each cycle with coin_req and coin_ack both high decrements the active counter by one.
REQ-025 coin_ack without coin_req is ignored.
REQ-026 Denominations with a zero count are skipped with no coin_req cycle.
- An all-zero payout goes PAY->DONE in one cycle.
REQ-027 DONE lasts one cycle with done=1, then returns to IDLE; sum holds its value until the next start.
REQ-028 start outside IDLE is ignored; V outside DRAW is ignored; draw_val>99 is accepted unclipped but still saturates at SUM_MAX.

Reset
REQ-029 While reset=0 at a clock edge:
- state<=IDLE.
- sum=0; finish, coin_req, busy, done and err = 0; coin_type=2'b00.
- All counters are cleared.
REQ-030 A reset asserted mid-round (any state, including PAY with coin_req high) aborts the round in the same edge; no done pulse is issued.

Configuration
REQ-031 Macro LOTTERY_ACK_TIMEOUT_EN, when defined:
- An 8-bit watchdog counts cycles with coin_req=1 and coin_ack=0.
- When the count reaches 255, the block sets err, drops coin_req and goes to DONE.
- Each accepted coin restarts the watchdog.
REQ-032 Without the macro, PAY waits for coin_ack indefinitely and no watchdog logic exists.

Structure
REQ-033 Package lottery_pkg holds:
- the state enumeration,
- the coin_type encodings,
- SUM_MAX default,
- widths 10/3/4.
REQ-034 Sub-module payout_seq implements PAY: the three BCD down-counters, denomination ordering, the req/ack handshake and the optional watchdog; lottery_ctrl holds the round FSM and the accumulator.

Verification
REQ-035 Draws 20,30,40,50,60 with V gaps between draws -> sum=200; finish pulses exactly once, one cycle after the 5th draw.
REQ-036 Draws 99 x5 with SUM_MAX=300 -> sum=300; no wrap-around.
REQ-037 In EVAL, winner=1 with Eur100=1, Eur010=2, Eur001=0, ack held high -> coin_type sequence 10,01,01; three coin_req cycles; then done.
REQ-038 Same payout, with ack asserted 3 cycles late for each coin -> coin_type stable while waiting; exactly 3 coins counted.
REQ-039 not_a_win=1 -> no coin_req; done one cycle after EVAL. winner=not_a_win=1 -> err=1, done.
REQ-040 reset=0 during PAY after the first coin -> next cycle is IDLE with outputs at reset values. With LOTTERY_ACK_TIMEOUT_EN and ack tied low -> err=1, done after 255 wait cycles.
